// File: rtl/i2c_master_write16_if.sv
// Bus bundle between the 16-bit register-write I2C initiator and its user/IO side.
// Handshake: start is a request sampled every clk and taken only while busy=0; busy then stays high through the done pulse.
interface i2c_master_write16_if;
    logic        start;
    logic [6:0]  addr;
    logic [15:0] data;
    logic        busy;
    logic        done;
    logic        nack;
    logic        scl;
    logic        sda_out;
    logic        sda_in;
    logic [2:0]  dbg_state;

    modport master (
        input  start, addr, data, sda_in,
        output busy, done, nack, scl, sda_out, dbg_state
    );

    modport slave (
        output start, addr, data, sda_in,
        input  busy, done, nack, scl, sda_out, dbg_state
    );
endinterface

// File: rtl/i2c_master_write16.sv
// I2C initiator for a single 16-bit register write: START, {addr,W}, data[15:8], data[7:0], STOP.
// Each FSM phase lasts one quarter SCL period of CLK_DIV clks; the ACK after every byte is checked.
module i2c_master_write16 #(
    parameter int CLK_DIV = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    i2c_master_write16_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    localparam int             QW     = $clog2(CLK_DIV);
    localparam logic [QW-1:0]  Q_LAST = QW'(CLK_DIV - 1);

    state_t         state;
    state_t         state_next;
    logic [QW-1:0]  q_cnt;
    logic [1:0]     phase;
    logic [3:0]     bit_cnt;
    logic [1:0]     byte_cnt;
    logic [26:0]    frame;
    logic           nack_q;
    logic           tick;
    logic           accept;
    logic           phase_last;
    logic           scl_c;
    logic           sda_c;

    assign tick   = (state != S_IDLE) && (q_cnt == Q_LAST);
    assign accept = (state == S_IDLE) && bus.start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        phase_last = 1'b0;
        scl_c      = 1'b1;
        sda_c      = 1'b1;
        case (state)
            S_IDLE: begin
                if (bus.start) state_next = S_START;
            end
            S_START: begin
                phase_last = (phase == 2'd1);
                scl_c      = (phase == 2'd0);
                sda_c      = 1'b0;
                if (tick && phase_last) state_next = S_BIT;
            end
            S_BIT: begin
                phase_last = (phase == 2'd3);
                scl_c      = (phase == 2'd1) || (phase == 2'd2);
                sda_c      = frame[26];
                if (tick && phase_last && (bit_cnt == 4'd7)) state_next = S_ACK;
            end
            S_ACK: begin
                phase_last = (phase == 2'd3);
                scl_c      = (phase == 2'd1) || (phase == 2'd2);
                sda_c      = 1'b1;
                // A NACK on any byte abandons the remaining bytes.
                if (tick && phase_last) begin
                    state_next = (nack_q || (byte_cnt == 2'd2)) ? S_STOP : S_BIT;
                end
            end
            S_STOP: begin
                phase_last = (phase == 2'd2);
                scl_c      = (phase != 2'd0);
                sda_c      = (phase == 2'd2);
                if (tick && phase_last) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_cnt    <= '0;
            phase    <= 2'd0;
            bit_cnt  <= 4'd0;
            byte_cnt <= 2'd0;
            frame    <= '0;
            nack_q   <= 1'b0;
        end else if (accept) begin
            // Frame carries released (1) slots where the slave answers.
            frame    <= {bus.addr, 1'b0, 1'b1, bus.data[15:8], 1'b1, bus.data[7:0], 1'b1};
            nack_q   <= 1'b0;
            bit_cnt  <= 4'd0;
            byte_cnt <= 2'd0;
            q_cnt    <= '0;
            phase    <= 2'd0;
        end else if (state != S_IDLE) begin
            q_cnt <= tick ? '0 : q_cnt + 1'b1;
            if (tick) begin
                phase <= phase_last ? 2'd0 : phase + 2'd1;
                if ((state == S_BIT) && phase_last) begin
                    frame   <= frame << 1;
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if ((state == S_ACK) && (phase == 2'd1) && bus.sda_in) begin
                    nack_q <= 1'b1;
                end
                if ((state == S_ACK) && phase_last) begin
                    frame    <= frame << 1;
                    bit_cnt  <= 4'd0;
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
        end
    end

    assign bus.scl       = scl_c;
    assign bus.sda_out   = sda_c;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_STOP) && tick && (phase == 2'd2);
    assign bus.nack      = nack_q;
    assign bus.dbg_state = state;

endmodule
